// File: rtl/inst_mem_pipe_pkg.sv
// Shared definitions for the instruction-memory fetch pipe.
// Contents:
//   LATENCY_MIN/LATENCY_MAX  legal range of the accept->response latency
//   NOP_INST                 instruction word carried by an errored fetch
//   ptr_width()              pointer width for a circular buffer of a given depth
package inst_mem_pipe_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 8;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // A depth-1 buffer still needs a 1-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/inst_mem_pipe_fifo.sv
// First-word-fall-through response buffer.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         drop every stored entry at this edge (wins over write/read)
//   i_wr_en         push i_wr_data (ignored when full)
//   i_wr_data       entry to push
//   i_rd_en         pop the head (ignored when empty)
//   o_valid         buffer holds at least one entry
//   o_data          head entry, zero when empty
module inst_mem_pipe_fifo
    import inst_mem_pipe_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Full/empty come from the separate count, never from pointer equality.
    assign do_rd = i_rd_en && (count != '0);
    assign do_wr = i_wr_en && (count != CNT_W'(DEPTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge i_clk) begin
        if (do_wr && !i_clear) begin
            store[wr_ptr] <= i_wr_data;
        end
    end

    assign o_valid = (count != '0);
    assign o_data  = o_valid ? store[rd_ptr] : '0;

endmodule

// File: rtl/inst_mem_pipe.sv
// Parametrised-latency instruction memory between PC generation and decode.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid, o_ready        fetch request handshake, i_addr is the byte address
//   o_valid, i_ready        response handshake, o_inst/o_err carry the result
//   i_flush                 discard everything in flight and buffered (redirect)
//   i_wr_en/_addr/_data     preload write port for the loader
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The request side never looks at i_ready, so o_ready depends only on the
// registered in-flight count and i_flush. A presented response holds o_inst and
// o_err stable until it is taken. When o_valid is low, o_inst and o_err are 0.
module inst_mem_pipe
    import inst_mem_pipe_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int INST_W    = 32,
    parameter int MAX_INST  = 256,
    parameter int LATENCY   = 3,
    parameter int OUT_DEPTH = 4
)
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic              o_err,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [INST_W-1:0] i_wr_data
);

    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int IDX_W  = ptr_width(MAX_INST);
    localparam int ENT_W  = INST_W + 1;
    localparam int STAGES = LATENCY - 1;

    logic [INST_W-1:0] mem [MAX_INST];
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              pop;
    logic [ADDR_W-1:0] rd_word;
    logic [ADDR_W-1:0] wr_word;
    logic              rd_err;
    logic              wr_ok;
    logic [ENT_W-1:0]  rd_entry;
    logic              fifo_wr;
    logic [ENT_W-1:0]  fifo_wdata;
    logic              fifo_valid;
    logic [ENT_W-1:0]  fifo_rdata;

    // cnt covers requests in the delay line plus entries in the buffer, so
    // capping it at OUT_DEPTH is what keeps the buffer from overflowing.
    assign o_ready = !i_flush && (cnt < CNT_W'(OUT_DEPTH));
    assign accept  = i_valid && o_ready;
    assign pop     = fifo_valid && i_ready && !i_flush;

    // Read side: combinational array read in the accept cycle.
    assign rd_word  = i_addr >> 2;
    assign rd_err   = (i_addr[1:0] != 2'b00) || (rd_word >= ADDR_W'(MAX_INST));
    assign rd_entry = rd_err ? {1'b1, INST_W'(NOP_INST)}
                             : {1'b0, mem[rd_word[IDX_W-1:0]]};

    // Preload: misaligned or out-of-range writes are dropped. A read of the
    // same word in the same cycle sees the old contents.
    assign wr_word = i_wr_addr >> 2;
    assign wr_ok   = i_wr_en && (i_wr_addr[1:0] == 2'b00) &&
                     (wr_word < ADDR_W'(MAX_INST));

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_word[IDX_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_flush) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Delay line: LATENCY-1 register stages; the buffer write is the last one.
    if (STAGES == 0) begin : g_no_delay
        assign fifo_wr    = accept;
        assign fifo_wdata = rd_entry;
    end else begin : g_delay
        logic [STAGES-1:0] stage_v;
        logic [ENT_W-1:0]  stage_d [STAGES];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                stage_v <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    stage_d[i] <= '0;
                end
            end else begin
                stage_v[0] <= accept;
                stage_d[0] <= rd_entry;
                for (int i = 1; i < STAGES; i++) begin
                    stage_v[i] <= stage_v[i-1];
                    stage_d[i] <= stage_d[i-1];
                end
                if (i_flush) begin
                    stage_v <= '0;
                end
            end
        end

        assign fifo_wr    = stage_v[STAGES-1];
        assign fifo_wdata = stage_d[STAGES-1];
    end

    inst_mem_pipe_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (OUT_DEPTH)
    ) u_resp_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_flush),
        .i_wr_en   (fifo_wr),
        .i_wr_data (fifo_wdata),
        .i_rd_en   (pop),
        .o_valid   (fifo_valid),
        .o_data    (fifo_rdata)
    );

    assign o_valid = fifo_valid;
    assign o_inst  = fifo_rdata[INST_W-1:0];
    assign o_err   = fifo_rdata[INST_W];

endmodule
